inst_fetch_queue: RTL and testbench

Instruction fetch stage that sits directly upstream of the single-cycle datapath. It reads the byte-wide instruction memory one byte per cycle and assembles big-endian 32-bit instructions, with the byte at the lowest address in bits 31:24. Completed instructions are buffered with their PC in a small FIFO and handed to the decode/execute datapath over a valid/ready handshake. The datapath sends branch redirects back into this block.

---
 rtl/inst_fetch_queue.sv | 117 +++++++++++
 tb/tb_inst_fetch_queue.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Byte-serial instruction fetch assembling big-endian words into a DEPTH-entry {pc,inst} FIFO.
// One word per 5 cycles; fetch starts a word only when a slot is free, so a stalled consumer parks it in IDLE.
module inst_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     CLK,
   input  logic                     RST,
   output logic                     imem_re,
   output logic [31:0]              imem_addr,
   input  logic [7:0]               imem_rdata,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   output logic                     inst_valid,
   input  logic                     inst_ready,
   output logic [31:0]              inst,
   output logic [31:0]              inst_pc,
   output logic [31:0]              inst_pc4,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, LAST} state_t;

   state_t        state, state_nxt;
   logic [1:0]    bi, bi_nxt;
   logic [31:0]   fetch_pc;
   logic [23:0]   asm_q;
   logic [31:0]   mem_pc   [DEPTH];
   logic [31:0]   mem_inst [DEPTH];
   logic [AW-1:0] rptr, wptr;
   logic          push, pop;
   logic [CW-1:0] count_post;

   assign pop        = inst_valid && inst_ready;
   assign push       = (state == LAST);
   assign count_post = count + CW'(push) - CW'(pop);

   assign inst_valid = (count != '0);
   assign inst       = mem_inst[rptr];
   assign inst_pc    = mem_pc[rptr];
   assign inst_pc4   = inst_pc + 32'd4;
   assign imem_addr  = fetch_pc + {30'b0, bi};

   always_comb begin
      state_nxt = state;
      bi_nxt    = bi;
      imem_re   = 1'b0;
      case (state)
         IDLE: begin
            if (count < FULL) begin
               state_nxt = ISSUE;
               bi_nxt    = 2'd0;
            end
         end
         ISSUE: begin
            imem_re = 1'b1;
            if (bi == 2'd3) begin
               state_nxt = LAST;
               bi_nxt    = 2'd0;
            end else begin
               bi_nxt = bi + 2'd1;
            end
         end
         LAST: begin
            bi_nxt    = 2'd0;
            // Reserve a slot for the next word against the post-edge occupancy.
            state_nxt = (count_post < FULL) ? ISSUE : IDLE;
         end
         default: begin
            state_nxt = IDLE;
            bi_nxt    = 2'd0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= IDLE;
         bi       <= 2'd0;
         fetch_pc <= RESET_PC;
         asm_q    <= '0;
         count    <= '0;
         rptr     <= '0;
         wptr     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_pc[i]   <= '0;
            mem_inst[i] <= '0;
         end
      end else if (redirect) begin
         state    <= ISSUE;
         bi       <= 2'd0;
         fetch_pc <= {redirect_pc[31:2], 2'b00};
         asm_q    <= '0;
         count    <= '0;
         rptr     <= '0;
         wptr     <= '0;
      end else begin
         state <= state_nxt;
         bi    <= bi_nxt;
         // Read data lags its request by one cycle; bi=0 cycles carry no live byte.
         if (state == ISSUE && bi != 2'd0)
            asm_q <= {asm_q[15:0], imem_rdata};
         if (push) begin
            mem_pc[wptr]   <= fetch_pc;
            mem_inst[wptr] <= {asm_q, imem_rdata};
            wptr           <= wptr + 1'b1;
            fetch_pc       <= fetch_pc + 32'd4;
         end
         if (pop)
            rptr <= rptr + 1'b1;
         count <= count_post;
      end
   end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with a word-level reference model checked every cycle.
module tb_inst_fetch_queue;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        CLK = 1'b0;
   logic        RST;
   logic        imem_re;
   logic [31:0] imem_addr;
   logic [7:0]  imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst, inst_pc, inst_pc4;
   logic [2:0]  count;

   int total = 0;
   int bad   = 0;

   inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .CLK(CLK), .RST(RST), .imem_re(imem_re), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
      .inst_pc(inst_pc), .inst_pc4(inst_pc4), .count(count)
   );

   always #5 CLK = ~CLK;

   function automatic logic [7:0] mb(input logic [31:0] a);
      case (a)
         32'd0:   return 8'h20;
         32'd1:   return 8'h08;
         32'd2:   return 8'h00;
         32'd3:   return 8'h05;
         default: return a[7:0] ^ {a[11:8], a[3:0]} ^ a[31:24] ^ 8'h5A;
      endcase
   endfunction

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return {mb(a), mb(a + 32'd1), mb(a + 32'd2), mb(a + 32'd3)};
   endfunction

   // Synchronous byte memory, one-cycle latency.
   always @(posedge CLK) begin
      if (imem_re === 1'b1) imem_rdata <= mb(imem_addr);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: queue of {pc,inst}; ph = -1 idle, 0..3 byte issue, 4 push cycle.
   logic [63:0] mq[$];
   int          ph   = -1;
   logic [31:0] mpc  = RESET_PC;
   bit          live = 0;

   always @(posedge CLK) begin
      int sz;
      bit mpop;
      sz   = mq.size();
      mpop = (sz != 0) && (inst_ready === 1'b1);
      if (RST === 1'b1) begin
         mq.delete(); ph = -1; mpc = RESET_PC; live = 1;
      end else if (redirect === 1'b1) begin
         mq.delete(); ph = 0; mpc = {redirect_pc[31:2], 2'b00};
      end else if (live) begin
         if (mpop) void'(mq.pop_front());
         if (ph == 4) begin
            mq.push_back({mpc, word_at(mpc)});
            mpc = mpc + 32'd4;
            ph  = (mq.size() < DEPTH) ? 0 : -1;
         end else if (ph == -1) begin
            ph = (sz < DEPTH) ? 0 : -1;
         end else begin
            ph++;
         end
      end
      #1;
      if (live) begin
         chk("m_valid", inst_valid, (mq.size() != 0));
         chk("m_count", count, mq.size());
         if (mq.size() != 0) begin
            chk("m_inst", inst, mq[0][31:0]);
            chk("m_pc", inst_pc, mq[0][63:32]);
            chk("m_pc4", inst_pc4, mq[0][63:32] + 32'd4);
         end
         chk("m_re", imem_re, (ph >= 0 && ph <= 3));
         if (ph >= 0 && ph <= 3) chk("m_addr", imem_addr, mpc + ph);
      end
   end

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_re"}, imem_re, 0);
      chk({tag, "_addr"}, imem_addr, RESET_PC);
      chk({tag, "_valid"}, inst_valid, 0);
      chk({tag, "_inst"}, inst, 0);
      chk({tag, "_pc"}, inst_pc, 0);
      chk({tag, "_pc4"}, inst_pc4, 32'd4);
      chk({tag, "_count"}, count, 0);
   endtask

   initial begin
      bit ok;
      RST = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
      repeat (2) tick();
      chk_reset_vals("rst");
      RST = 1'b0;

      // First word: visible after the sixth edge.
      repeat (6) tick();
      chk("e6_valid", inst_valid, 1);
      chk("e6_inst", inst, 32'h2008_0005);
      chk("e6_pc", inst_pc, 32'h0);
      chk("e6_pc4", inst_pc4, 32'h4);
      repeat (20) tick();

      // Stall until full, then release a single slot.
      inst_ready = 1'b0;
      ok = 0;
      for (int i = 0; i < 60; i++) begin tick(); if (count == 3'd4) begin ok = 1; break; end end
      chk("full_wait", ok, 1);
      repeat (3) begin tick(); chk("idle_re", imem_re, 0); end
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      chk("pop_count", count, 3);
      chk("bubble_re", imem_re, 0);
      tick();
      chk("resume_re", imem_re, 1);
      repeat (5) tick();
      chk("refill_count", count, 4);

      // Redirect during byte 2 with two words buffered.
      redirect = 1'b1; redirect_pc = 32'h0;
      tick();
      redirect = 1'b0;
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (count == 3'd2 && imem_re && imem_addr[1:0] == 2'd2) begin ok = 1; break; end
      end
      chk("bi2_wait", ok, 1);
      redirect = 1'b1; redirect_pc = 32'h0000_0042;
      tick();
      redirect = 1'b0;
      chk("redir_count", count, 0);
      chk("redir_addr0", imem_addr, 32'h40);
      for (int k = 1; k < 4; k++) begin
         tick();
         chk("redir_addr", imem_addr, 32'h40 + k);
      end
      ok = 0;
      for (int i = 0; i < 10; i++) begin tick(); if (inst_valid) begin ok = 1; break; end end
      chk("redir_wait", ok, 1);
      chk("redir_pc", inst_pc, 32'h40);
      chk("redir_cnt1", count, 1);

      // Reset in the push cycle with three words buffered.
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (count == 3'd3 && imem_re && imem_addr[1:0] == 2'd3) begin ok = 1; break; end
      end
      chk("last_wait", ok, 1);
      tick();
      RST = 1'b1;
      tick();
      chk_reset_vals("rst_last");
      RST = 1'b0;
      tick();
      chk("restart_re", imem_re, 1);
      chk("restart_addr", imem_addr, RESET_PC);

      // Redirect to the top word; PC+4 wraps and fetch continues at zero.
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      tick();
      redirect = 1'b0;
      ok = 0;
      for (int i = 0; i < 10; i++) begin tick(); if (inst_valid) begin ok = 1; break; end end
      chk("wrap_wait", ok, 1);
      chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
      chk("wrap_pc4", inst_pc4, 32'h0);
      chk("wrap_next_re", imem_re, 1);
      chk("wrap_next_addr", imem_addr, 32'h0);

      inst_ready = 1'b1;
      repeat (20) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
